// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the baud generator.
package uart_pkg;

  // Oversampling ratio used by the receiver unless overridden.
  localparam int UART_OVS_DEFAULT = 16;

  // 50 MHz clock, 9600 baud, x16 oversampling: 325.5 cycles per rx tick.
  localparam int UART_DIV_INT_9600_50M  = 325;
  localparam int UART_DIV_FRAC_9600_50M = 8;

  // Smallest integer divisor the counter supports.
  localparam int UART_DIV_MIN = 2;

  // Divisor shadow state: IDLE = active divisor is current,
  // PENDING = shadow holds a divisor waiting for the next transfer point.
  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle of the fractional baud generator.
//
// Protocol: cfg_load and rx_resync are single-cycle strobes sampled on every
// rising clk edge; the generator accepts them in any cycle, so there is no
// ready. cfg_busy is high while a loaded divisor is waiting in the shadow.
// rx_enb and tx_enb are registered single-cycle strobes; tx_enb is only ever
// high together with rx_enb.
interface uart_baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();

  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              cfg_load;
  logic              rx_resync;
  logic              rx_enb;
  logic              tx_enb;
  logic              cfg_busy;

  // Side that programs the generator and consumes the ticks.
  modport master (
    output en, div_int, div_frac, cfg_load, rx_resync,
    input  rx_enb, tx_enb, cfg_busy
  );

  // Baud generator side.
  modport slave (
    input  en, div_int, div_frac, cfg_load, rx_resync,
    output rx_enb, tx_enb, cfg_busy
  );

endinterface

// File: rtl/uart_frac_divider.sv
// Fractional cycle divider: counts periods of act_int or act_int+1 cycles so
// that the average period is act_int + act_frac/2^FRAC_W. Emits a wrap strobe
// on the last cycle of each period.
module uart_frac_divider
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  act_int,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              wrap
);

  // One extra bit: a period can be 2^DIV_W-1 + 1 cycles long.
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;

  logic [DIV_W-1:0]  int_clamped;
  logic [DIV_W:0]    len_m1;
  logic [FRAC_W:0]   acc_sum;

  // Period length and wrap detection. The >= compare lets a divisor that was
  // shortened while the counter was frozen end the period at the next enabled
  // cycle instead of running the counter up to overflow.
  always_comb begin
    int_clamped = (act_int < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : act_int;
    len_m1      = {1'b0, int_clamped} + {{DIV_W{1'b0}}, extra} - (DIV_W+1)'(1);
    wrap        = en && (cnt >= len_m1);
    acc_sum     = {1'b0, acc} + {1'b0, act_frac};
  end

  // Cycle counter and fraction accumulator; the accumulator carry stretches
  // the following period by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      acc   <= acc_sum[FRAC_W-1:0];
      extra <= acc_sum[FRAC_W];
    end else if (en) begin
      cnt   <= cnt + (DIV_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: programmable divisor with a shadow register,
// oversampling tick rx_enb and bit tick tx_enb every OVS-th rx_enb.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OVS            = UART_OVS_DEFAULT,
  parameter int RESET_DIV_INT  = UART_DIV_INT_9600_50M,
  parameter int RESET_DIV_FRAC = UART_DIV_FRAC_9600_50M
) (
  input logic                 clk,
  input logic                 rst,
  uart_baud_gen_frac_if.slave bus
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  cfg_state_e        cfg_q;
  cfg_state_e        cfg_d;
  logic              xfer;

  logic              wrap;
  logic              tick;
  logic              last_ovs;
  logic [OVS_W-1:0]  ovs_cnt;
  logic              rx_enb_q;
  logic              tx_enb_q;

  uart_frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .clr      (bus.rx_resync),
    .act_int  (act_int),
    .act_frac (act_frac),
    .wrap     (wrap)
  );

  // A resync suppresses the tick the divider would have produced this cycle.
  assign tick     = wrap && !bus.rx_resync;
  assign last_ovs = (ovs_cnt == OVS_W'(OVS - 1));

  // Shadow state: a pending divisor moves to active at a period boundary, at a
  // resync, or at once while counting is frozen. A load coinciding with a
  // resync bypasses the shadow, so it leaves nothing pending.
  always_comb begin
    cfg_d = cfg_q;
    xfer  = 1'b0;
    if (cfg_q == CFG_PENDING && (wrap || !bus.en || bus.rx_resync)) begin
      xfer  = 1'b1;
      cfg_d = CFG_IDLE;
    end
    if (bus.cfg_load) begin
      cfg_d = bus.rx_resync ? CFG_IDLE : CFG_PENDING;
    end
  end

  // Shadow state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= CFG_IDLE;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Shadow and active divisor registers; the newest loaded value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int  <= DIV_W'(RESET_DIV_INT);
      act_frac <= FRAC_W'(RESET_DIV_FRAC);
      sh_int   <= DIV_W'(RESET_DIV_INT);
      sh_frac  <= FRAC_W'(RESET_DIV_FRAC);
    end else begin
      if (bus.cfg_load) begin
        sh_int  <= bus.div_int;
        sh_frac <= bus.div_frac;
      end
      if (bus.cfg_load && bus.rx_resync) begin
        act_int  <= bus.div_int;
        act_frac <= bus.div_frac;
      end else if (xfer) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
    end
  end

  // Oversampling counter and registered tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovs_cnt  <= '0;
      rx_enb_q <= 1'b0;
      tx_enb_q <= 1'b0;
    end else begin
      rx_enb_q <= tick;
      tx_enb_q <= tick && last_ovs;
      if (bus.rx_resync) begin
        ovs_cnt <= '0;
      end else if (tick) begin
        ovs_cnt <= last_ovs ? '0 : ovs_cnt + OVS_W'(1);
      end
    end
  end

  assign bus.rx_enb   = rx_enb_q;
  assign bus.tx_enb   = tx_enb_q;
  assign bus.cfg_busy = (cfg_q == CFG_PENDING);

endmodule
